// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, LCR word-length decode
// and the parity rule used by both transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  function automatic logic [3:0] wls_to_len(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 4'd5;
      WLS_6:   return 4'd6;
      WLS_7:   return 4'd7;
      WLS_8:   return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

  // Unused data bits must be zero so the reduction covers only the real word.
  function automatic logic parity_expected(input logic [7:0] data, input logic eps,
                                           input logic sp);
    if (sp) return ~eps;
    return eps ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for asynchronous inputs; flops reset to RST_VAL so an
// idle-high line does not look like an edge when reset is released.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: mid-bit sampling on the oversampled baud tick,
// parity / framing / break detection and a one-cycle push per character.
//
// state    | meaning
// IDLE     | line idle, waiting for a low level on rxs
// START    | timing to the middle of the start bit to reject glitches
// DATA     | sampling data bits LSB first
// PARITY   | sampling the parity bit
// STOP     | sampling the first stop bit, push issued here
// BRK_WAIT | break reported, waiting for the line to return high
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  output logic [7:0] rx_data,
  output logic       rx_push,
  output logic       pe,
  output logic       fe,
  output logic       bi
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  rx_state_t        state, state_nxt;
  logic             rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bcnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [1:0]       frm_wls;
  logic             frm_pen, frm_eps, frm_sp;
  logic             start_frame, smp_start, smp_bit, smp_par, smp_stop;
  logic             last_bit, brk_now;

  uart_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  assign last_bit = ({1'b0, bcnt} == (wls_to_len(frm_wls) - 4'd1));
  assign brk_now  = (shreg == 8'h00) && (!frm_pen || !par_bit) && !rxs;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_frame) state_nxt = START;
      START:    if (smp_start) state_nxt = rxs ? IDLE : DATA;
      DATA:     if (smp_bit && last_bit) state_nxt = frm_pen ? PARITY : STOP;
      PARITY:   if (smp_par) state_nxt = STOP;
      STOP:     if (smp_stop) state_nxt = brk_now ? BRK_WAIT : IDLE;
      BRK_WAIT: if (rxs) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    smp_start   = 1'b0;
    smp_bit     = 1'b0;
    smp_par     = 1'b0;
    smp_stop    = 1'b0;
    case (state)
      IDLE:    start_frame = !rxs;
      START:   smp_start   = baud_tick && (cnt == HALF);
      DATA:    smp_bit     = baud_tick && (cnt == LAST);
      PARITY:  smp_par     = baud_tick && (cnt == LAST);
      STOP:    smp_stop    = baud_tick && (cnt == LAST);
      default: ;
    endcase
  end

  // LCR fields are frozen per character so a mid-frame rewrite cannot corrupt it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      frm_wls <= '0;
      frm_pen <= 1'b0;
      frm_eps <= 1'b0;
      frm_sp  <= 1'b0;
      rx_data <= '0;
      rx_push <= 1'b0;
      pe      <= 1'b0;
      fe      <= 1'b0;
      bi      <= 1'b0;
    end else begin
      rx_push <= smp_stop;
      if (start_frame) begin
        cnt     <= '0;
        shreg   <= '0;
        par_bit <= 1'b0;
        frm_wls <= wls;
        frm_pen <= pen;
        frm_eps <= eps;
        frm_sp  <= sp;
      end else if (state == IDLE || state == BRK_WAIT) begin
        cnt <= '0;
      end else if (baud_tick) begin
        cnt <= (smp_start || smp_bit || smp_par || smp_stop) ? '0 : cnt + 1'b1;
      end
      if (smp_start) bcnt <= '0;
      if (smp_bit) begin
        shreg[bcnt] <= rxs;
        bcnt        <= bcnt + 3'd1;
      end
      if (smp_par) par_bit <= rxs;
      if (smp_stop) begin
        rx_data <= shreg;
        pe      <= frm_pen && (par_bit != parity_expected(shreg, frm_eps, frm_sp));
        fe      <= !rxs;
        bi      <= brk_now;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frames are driven bit by bit at 64 clk per
// bit (baud tick every 4 clk, 16 ticks per bit) and pushes are captured off-edge.
module tb_uart_rx_deser;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [1:0] wls;
  logic       pen, eps, sp;
  logic [7:0] rx_data;
  logic       rx_push, pe, fe, bi;

  int vectors = 0;
  int errors  = 0;

  int         push_cnt   = 0;
  int         tick_cnt   = 0;
  int         push_tick  = 0;
  int         dbl_push   = 0;
  int         start_tick = 0;
  logic       prev_push  = 1'b0;
  logic [7:0] cap_data   = 8'h00;
  logic       cap_pe = 1'b0, cap_fe = 1'b0, cap_bi = 1'b0;
  logic [1:0] tdiv = 2'd0;

  uart_rx_deser #(
    .SYNC_STAGES(2),
    .OVERSAMPLE (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .rx       (rx),
    .wls      (wls),
    .pen      (pen),
    .eps      (eps),
    .sp       (sp),
    .rx_data  (rx_data),
    .rx_push  (rx_push),
    .pe       (pe),
    .fe       (fe),
    .bi       (bi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv <= tdiv + 2'd1;
    if (tdiv == 2'd3) tick_cnt <= tick_cnt + 1;
  end
  assign baud_tick = (tdiv == 2'd3);

  always @(negedge clk) begin
    if (rx_push) begin
      push_cnt  = push_cnt + 1;
      push_tick = tick_cnt;
      cap_data  = rx_data;
      cap_pe    = pe;
      cap_fe    = fe;
      cap_bi    = bi;
      if (prev_push) dbl_push = dbl_push + 1;
    end
    prev_push = rx_push;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int len, input logic has_par,
                            input logic par_bit, input logic stop_bit, input int stop_clks);
    @(negedge clk);
    start_tick = tick_cnt;
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < len; i++) begin
      rx = d[i];
      wait_clks(64);
    end
    if (has_par) begin
      rx = par_bit;
      wait_clks(64);
    end
    rx = stop_bit;
    wait_clks(stop_clks);
    rx = 1'b1;
    wait_clks(128);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    wls = 2'b11;
    pen = 1'b0;
    eps = 1'b0;
    sp  = 1'b0;
    wait_clks(4);
    vectors += 5;
    if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data: got %h want 00", rx_data); errors++; end
    if (rx_push !== 1'b0) begin $display("FAIL reset_rx_push: got %b want 0", rx_push); errors++; end
    if (pe !== 1'b0) begin $display("FAIL reset_pe: got %b want 0", pe); errors++; end
    if (fe !== 1'b0) begin $display("FAIL reset_fe: got %b want 0", fe); errors++; end
    if (bi !== 1'b0) begin $display("FAIL reset_bi: got %b want 0", bi); errors++; end
    rst = 1'b0;
    wait_clks(8);
  endtask

  task automatic test_8n1();
    int p0, lat;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    p0 = push_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 64);
    lat = push_tick - start_tick;
    vectors += 6;
    if (push_cnt !== p0 + 1) begin $display("FAIL 8n1_pushes: got %0d want %0d", push_cnt - p0, 1); errors++; end
    if (cap_data !== 8'hA5) begin $display("FAIL 8n1_data: got %h want a5", cap_data); errors++; end
    if (cap_pe !== 1'b0) begin $display("FAIL 8n1_pe: got %b want 0", cap_pe); errors++; end
    if (cap_fe !== 1'b0) begin $display("FAIL 8n1_fe: got %b want 0", cap_fe); errors++; end
    if (cap_bi !== 1'b0) begin $display("FAIL 8n1_bi: got %b want 0", cap_bi); errors++; end
    if (lat < 151 || lat > 153) begin $display("FAIL 8n1_latency: got %0d ticks want 152+-1", lat); errors++; end
  endtask

  task automatic test_parity5();
    int p0;
    wls = 2'b00; pen = 1'b1; eps = 1'b0; sp = 1'b0;
    // 0x10 has one set bit; odd parity bit 0 is correct, 1 is an error.
    p0 = push_cnt;
    send_frame(8'h10, 5, 1'b1, 1'b0, 1'b1, 64);
    vectors += 3;
    if (push_cnt !== p0 + 1) begin $display("FAIL par5_ok_pushes: got %0d want 1", push_cnt - p0); errors++; end
    if (cap_data !== 8'h10) begin $display("FAIL par5_ok_data: got %h want 10", cap_data); errors++; end
    if (cap_pe !== 1'b0) begin $display("FAIL par5_ok_pe: got %b want 0", cap_pe); errors++; end
    p0 = push_cnt;
    send_frame(8'h10, 5, 1'b1, 1'b1, 1'b1, 64);
    vectors += 4;
    if (push_cnt !== p0 + 1) begin $display("FAIL par5_bad_pushes: got %0d want 1", push_cnt - p0); errors++; end
    if (cap_data !== 8'h10) begin $display("FAIL par5_bad_data: got %h want 10", cap_data); errors++; end
    if (cap_pe !== 1'b1) begin $display("FAIL par5_bad_pe: got %b want 1", cap_pe); errors++; end
    if (cap_fe !== 1'b0) begin $display("FAIL par5_bad_fe: got %b want 0", cap_fe); errors++; end
  endtask

  task automatic test_framing_7e1();
    int p0;
    wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
    // 0x3F: six ones, even parity bit 0. Stop held low for 3/4 bit so the
    // trailing low level is rejected as a false start.
    p0 = push_cnt;
    send_frame(8'h3F, 7, 1'b1, 1'b0, 1'b0, 48);
    vectors += 5;
    if (push_cnt !== p0 + 1) begin $display("FAIL 7e1_fe_pushes: got %0d want 1", push_cnt - p0); errors++; end
    if (cap_data !== 8'h3F) begin $display("FAIL 7e1_fe_data: got %h want 3f", cap_data); errors++; end
    if (cap_fe !== 1'b1) begin $display("FAIL 7e1_fe_fe: got %b want 1", cap_fe); errors++; end
    if (cap_bi !== 1'b0) begin $display("FAIL 7e1_fe_bi: got %b want 0", cap_bi); errors++; end
    if (cap_pe !== 1'b0) begin $display("FAIL 7e1_fe_pe: got %b want 0", cap_pe); errors++; end
    p0 = push_cnt;
    send_frame(8'h01, 7, 1'b1, 1'b1, 1'b1, 64);
    vectors += 4;
    if (push_cnt !== p0 + 1) begin $display("FAIL 7e1_next_pushes: got %0d want 1", push_cnt - p0); errors++; end
    if (cap_data !== 8'h01) begin $display("FAIL 7e1_next_data: got %h want 01", cap_data); errors++; end
    if (cap_fe !== 1'b0) begin $display("FAIL 7e1_next_fe: got %b want 0", cap_fe); errors++; end
    if (cap_pe !== 1'b0) begin $display("FAIL 7e1_next_pe: got %b want 0", cap_pe); errors++; end
  endtask

  task automatic test_break();
    int p0;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    p0 = push_cnt;
    @(negedge clk);
    rx = 1'b0;
    wait_clks(3 * 10 * 64);
    rx = 1'b1;
    wait_clks(128);
    vectors += 5;
    if (push_cnt !== p0 + 1) begin $display("FAIL brk_pushes: got %0d want 1", push_cnt - p0); errors++; end
    if (cap_data !== 8'h00) begin $display("FAIL brk_data: got %h want 00", cap_data); errors++; end
    if (cap_bi !== 1'b1) begin $display("FAIL brk_bi: got %b want 1", cap_bi); errors++; end
    if (cap_fe !== 1'b1) begin $display("FAIL brk_fe: got %b want 1", cap_fe); errors++; end
    if (cap_pe !== 1'b0) begin $display("FAIL brk_pe: got %b want 0", cap_pe); errors++; end
    p0 = push_cnt;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 64);
    vectors += 4;
    if (push_cnt !== p0 + 1) begin $display("FAIL brk_next_pushes: got %0d want 1", push_cnt - p0); errors++; end
    if (cap_data !== 8'h55) begin $display("FAIL brk_next_data: got %h want 55", cap_data); errors++; end
    if (cap_bi !== 1'b0) begin $display("FAIL brk_next_bi: got %b want 0", cap_bi); errors++; end
    if (cap_fe !== 1'b0) begin $display("FAIL brk_next_fe: got %b want 0", cap_fe); errors++; end
  endtask

  task automatic test_glitch_and_reset();
    int p0;
    logic [7:0] c3;
    c3 = 8'hC3;
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    p0 = push_cnt;
    @(negedge clk);
    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(128);
    vectors += 2;
    if (push_cnt !== p0) begin $display("FAIL glitch_pushes: got %0d want 0", push_cnt - p0); errors++; end
    if (dut.state !== IDLE) begin $display("FAIL glitch_state: got %0d want %0d", dut.state, IDLE); errors++; end

    p0 = push_cnt;
    @(negedge clk);
    rx = 1'b0;
    wait_clks(64);
    for (int i = 0; i < 3; i++) begin
      rx = c3[i];
      wait_clks(64);
    end
    rx = c3[3];
    wait_clks(32);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clks(128);
    vectors += 5;
    if (push_cnt !== p0) begin $display("FAIL rst_pushes: got %0d want 0", push_cnt - p0); errors++; end
    if (rx_data !== 8'h00) begin $display("FAIL rst_rx_data: got %h want 00", rx_data); errors++; end
    if (pe !== 1'b0) begin $display("FAIL rst_pe: got %b want 0", pe); errors++; end
    if (fe !== 1'b0) begin $display("FAIL rst_fe: got %b want 0", fe); errors++; end
    if (bi !== 1'b0) begin $display("FAIL rst_bi: got %b want 0", bi); errors++; end

    p0 = push_cnt;
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 64);
    vectors += 3;
    if (push_cnt !== p0 + 1) begin $display("FAIL rst_next_pushes: got %0d want 1", push_cnt - p0); errors++; end
    if (cap_data !== 8'hC3) begin $display("FAIL rst_next_data: got %h want c3", cap_data); errors++; end
    if (cap_fe !== 1'b0) begin $display("FAIL rst_next_fe: got %b want 0", cap_fe); errors++; end
  endtask

  task automatic test_back_to_back();
    int p0;
    wls = 2'b11; pen = 1'b1; eps = 1'b0; sp = 1'b1;
    // Stick parity with eps=0 requires a parity bit of 1; LCR is changed
    // mid-frame and must not affect the character in flight.
    p0 = push_cnt;
    fork
      send_frame(8'h80, 8, 1'b1, 1'b1, 1'b1, 64);
      begin
        wait_clks(200);
        wls = 2'b00;
        pen = 1'b0;
      end
    join
    vectors += 4;
    if (push_cnt !== p0 + 1) begin $display("FAIL stick_pushes: got %0d want 1", push_cnt - p0); errors++; end
    if (cap_data !== 8'h80) begin $display("FAIL stick_data: got %h want 80", cap_data); errors++; end
    if (cap_pe !== 1'b0) begin $display("FAIL stick_pe: got %b want 0", cap_pe); errors++; end
    if (dbl_push !== 0) begin $display("FAIL push_consecutive: got %0d want 0", dbl_push); errors++; end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity5();
    test_framing_7e1();
    test_break();
    test_glitch_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Serial receive deserializer for the UART. It sits between the `rx` pin and the receive holding register/FIFO, and is clocked by the shared system clock. It uses the 16x baud tick from the register/baud block and the same LCR frame fields the transmitter uses. For each character it recovers the data, checks parity and the first stop bit, and emits a one-cycle push with PE, FE and BI status.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages in the `rx` synchronizer; must be at least 2.
- `OVERSAMPLE`, default 16: `baud_tick` pulses per bit time; must be even.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high.
- `baud_tick`  in  1  one-`clk` pulse at 16x the baud rate (divisor-derived).
- `rx`  in  1  asynchronous serial input; idle high.
- `wls`  in  2  LCR[1:0] word length: 00→5, 01→6, 10→7, 11→8 bits.
- `pen`  in  1  LCR[3] parity enable.
- `eps`  in  1  LCR[4] even parity select.
- `sp`  in  1  LCR[5] stick parity.
- `rx_data`  out  8  received character, LSB-first assembled; unused upper bits are 0.
- `rx_push`  out  1  one-cycle strobe: `rx_data`, `pe`, `fe` and `bi` are valid in this cycle.
- `pe`  out  1  parity error for the pushed character.
- `fe`  out  1  framing error (first stop bit sampled 0).
- `bi`  out  1  break: data, parity and stop bits all sampled 0.

## Operation
- `rx` passes through `SYNC_STAGES` flops. All logic below uses the synchronized value `rxs`.
- Tick counter `cnt` is 4 bits and advances only on `baud_tick`. Bit counter `bcnt` is 3 bits.
- The LCR inputs are sampled into a frame register on the IDLE→START transition. A mid-frame LCR change does not affect the character in flight.
- States and transitions:
  - IDLE: `rxs`==0 → START with `cnt`=0.
  - START: on the tick where `cnt`==OVERSAMPLE/2−1, sample `rxs`.
    - `rxs`==1 → IDLE (false start, no push).
    - `rxs`==0 → DATA with `cnt`=0 and `bcnt`=0.
  - DATA: on the tick where `cnt`==OVERSAMPLE−1, shift `rxs` into bit `bcnt` and clear `cnt`. After bit (wordlen−1), go to PARITY if `pen`, else STOP.
  - PARITY: sample at `cnt`==OVERSAMPLE−1, then go to STOP.
  - STOP: sample at `cnt`==OVERSAMPLE−1 and assert `rx_push` for that one cycle.
    - If `bi` → BRK_WAIT.
    - Otherwise → IDLE. A start bit beginning immediately after the stop bit is accepted.
  - BRK_WAIT: remain until `rxs`==1, then go to IDLE. This prevents repeated break pushes while the line is held low.
- Parity check, with ones = popcount(data bits) + received parity bit:
  - `sp`=0: `eps`=1 requires ones even; `eps`=0 requires ones odd.
  - `sp`=1: the parity bit must equal ~`eps`.
- `pe`=1 on mismatch. It is always 0 when `pen`=0.
- `fe` = ~stop sample. `bi` = all data bits 0, parity bit 0 (if enabled) and stop sample 0. `bi` implies `fe`. `pe` is also reported per the rule above.
- Only the first stop bit is checked; LCR[2] is ignored by the receiver.

## Timing
- Reset values: `rx_data`=0, `rx_push`=0, `pe`=`fe`=`bi`=0, state IDLE, `cnt`=`bcnt`=0. Synchronizer flops reset to 1.
- `rx_data`, `pe`, `fe` and `bi` are registered and hold their value until the next push.
- Latency, measured from the synchronized falling edge to `rx_push`: OVERSAMPLE/2 + OVERSAMPLE × (wordlen + pen + 1) ticks, ±1 tick of start-edge quantization. The synchronizer adds `SYNC_STAGES` cycles ahead of that.
- `rx_push` is never asserted in two consecutive `clk` cycles.
- `rst` asserted mid-frame aborts the frame in the next cycle with no push.
- A `baud_tick` held permanently high is legal; the block then runs at OVERSAMPLE clk cycles per bit.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, PARITY, STOP, BRK_WAIT}.
  - WLS encodings and the function `wls_to_len(wls)` returning 5..8.
  - The parity-expected function, shared with the transmitter.
- Sub-module `uart_sync`: parameterized multi-flop synchronizer with a reset value of 1, reused for other asynchronous inputs.

## Test plan
All cases drive `baud_tick` every 4 `clk` cycles.
- 8N1 (`wls`=11, `pen`=0), send 0xA5 → exactly one `rx_push` with `rx_data`=0xA5 and `pe`=`fe`=`bi`=0. The push lands 8+16×9 ticks after the start edge, ±1 tick.
- 5-bit odd parity (LCR 0x0C), send data 0x10 with parity bit 0 → `rx_data`=0x10, `pe`=0.
  - Repeat with parity bit 1 → `pe`=1.
- 7E1 (`wls`=10, `pen`=1, `eps`=1), send 0x3F with stop bit 0 → `rx_data`=0x3F, `fe`=1, `bi`=0. A following valid frame 0x01 is received correctly.
- Break: hold `rx` low for 3 character times in 8N1 → one push with `rx_data`=0x00 and `bi`=`fe`=1, then no further push. After `rx` returns high, frame 0x55 is received normally.
- Glitch: `rx` low for 5 ticks, then high → no push, state back to IDLE.
  - Then assert `rst` for 1 cycle mid-way through a 0xC3 frame → no push and all outputs 0. The next full frame 0xC3 is received intact.
